// File: rtl/nn_pkg.sv
// Shared types and constants for the training sequencer and the network it drives.
package nn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StTrain,
        StValid,
        StGap,
        StDone
    } seq_state_t;

    localparam int unsigned DEFAULT_BITS    = 32;
    localparam logic [31:0] DEFAULT_LR_INIT = 32'h0000_0100;

endpackage

// File: rtl/train_sequencer_if.sv
// Pattern-memory port plus the sequencer/network handshake, bundled as one interface.
interface train_sequencer_if #(
    parameter int unsigned NX   = 6,
    parameter int unsigned BITS = nn_pkg::DEFAULT_BITS,
    parameter int unsigned AW   = 5
);

    logic [AW-1:0]           pat_addr;
    logic [NX-1:0][BITS-1:0] pat_x;
    logic [BITS-1:0]         pat_y;
    logic [NX-1:0][BITS-1:0] x;
    logic [BITS-1:0]         y;
    logic [BITS-1:0]         lr;
    logic                    TR;
    logic                    VL;
    logic                    S_Train;
    logic                    S_Error;
    logic [BITS-1:0]         Error;

    modport master (
        output pat_addr, x, y, lr, TR, VL,
        input  pat_x, pat_y, S_Train, S_Error, Error
    );

    modport slave (
        input  pat_addr, x, y, lr, TR, VL,
        output pat_x, pat_y, S_Train, S_Error, Error
    );

endinterface

// File: rtl/train_sequencer.sv
// Steps a network through training/validation epochs, counting validation errors
// and stopping on an error-free epoch or after the epoch limit.
module train_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned     NX       = 6,
    parameter int unsigned     BITS     = DEFAULT_BITS,
    parameter int unsigned     NTRAIN   = 16,
    parameter int unsigned     NVAL     = 8,
    parameter int unsigned     EPOCHS   = 100,
    parameter logic [BITS-1:0] LR_INIT  = BITS'(DEFAULT_LR_INIT),
    parameter int unsigned     LR_DECAY = 10,
    localparam int unsigned    AW       = $clog2(NTRAIN + NVAL),
    localparam int unsigned    EW       = $clog2(NVAL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    train_sequencer_if.master bus,
    output logic              END,
    output logic [EW-1:0]     err_count,
    output logic [EW-1:0]     last_err,
    output logic [15:0]       epoch,
    output logic              busy
);

    localparam logic [AW-1:0] TRAIN_END = AW'(NTRAIN);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NTRAIN + NVAL - 1);
    localparam logic [15:0]   EPOCH_MAX = 16'(EPOCHS);
    // Divisor kept nonzero so the modulo stays legal when decay is disabled.
    localparam logic [15:0]   DECAY_DIV = 16'((LR_DECAY == 0) ? 1 : LR_DECAY);

    seq_state_t              state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [15:0]             epoch_q, epoch_d;
    logic [BITS-1:0]         lr_q, lr_d;
    logic [EW-1:0]           err_q, err_d;
    logic [EW-1:0]           last_q, last_d;
    logic [NX-1:0][BITS-1:0] x_q, x_d;
    logic [BITS-1:0]         y_q, y_d;

    logic [15:0]     epoch_inc;
    logic [BITS-1:0] lr_half;
    logic            decay_hit;

    assign epoch_inc = epoch_q + 16'd1;
    assign lr_half   = lr_q >> 1;
    assign decay_hit = (LR_DECAY != 0) && ((epoch_inc % DECAY_DIV) == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            epoch_q <= '0;
            lr_q    <= LR_INIT;
            err_q   <= '0;
            last_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            lr_q    <= lr_d;
            err_q   <= err_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        lr_d    = lr_q;
        err_d   = err_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    epoch_d = '0;
                    lr_d    = LR_INIT;
                    err_d   = '0;
                    last_d  = '0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                x_d     = bus.pat_x;
                y_d     = bus.pat_y;
                state_d = (idx_q < TRAIN_END) ? StTrain : StValid;
            end
            StTrain: begin
                if (bus.S_Train) state_d = StGap;
            end
            StValid: begin
                if (bus.S_Error) begin
                    state_d = StGap;
                    if (bus.Error != '0) err_d = err_q + 1'b1;
                end
            end
            StGap: begin
                if (!bus.S_Train && !bus.S_Error) begin
                    if (idx_q == LAST_IDX) begin
                        // Epoch end folded into the GAP exit.
                        idx_d   = '0;
                        epoch_d = epoch_inc;
                        last_d  = err_q;
                        err_d   = '0;
                        if (decay_hit) lr_d = (lr_half == '0) ? BITS'(1) : lr_half;
                        state_d = (epoch_inc == EPOCH_MAX || err_q == '0) ? StDone : StFetch;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.pat_addr = idx_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.lr       = lr_q;
    assign bus.TR       = (state_q == StTrain);
    assign bus.VL       = (state_q == StValid);
    assign END          = (state_q == StDone);
    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign err_count    = err_q;
    assign last_err     = last_q;
    assign epoch        = epoch_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Randomized bench for train_sequencer: behavioural network + memory, epoch-level reference model.
module tb_train_sequencer;
    import nn_pkg::*;

    localparam int unsigned     NX       = 6;
    localparam int unsigned     BITS     = 32;
    localparam int unsigned     NTRAIN   = 4;
    localparam int unsigned     NVAL     = 2;
    localparam int unsigned     EPOCHS   = 3;
    localparam int unsigned     LR_DECAY = 2;
    localparam logic [BITS-1:0] LR_INIT  = 32'h0000_0100;
    localparam int unsigned     NPAT     = NTRAIN + NVAL;
    localparam int unsigned     AW       = $clog2(NPAT);
    localparam int unsigned     EW       = $clog2(NVAL + 1);
    localparam int unsigned     NPLAN    = NVAL * EPOCHS;

    typedef struct packed {
        logic                    is_val;
        logic [NX-1:0][BITS-1:0] x;
        logic [BITS-1:0]         y;
        logic [BITS-1:0]         lr;
    } ev_t;

    typedef struct packed {
        logic [15:0]     epoch;
        logic [EW-1:0]   last_err;
        logic [EW-1:0]   err_count;
        logic [BITS-1:0] lr;
        logic            tr;
        logic            vl;
        logic            fin;
        logic            busy;
    } snap_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic           END;
    logic [EW-1:0]  err_count;
    logic [EW-1:0]  last_err;
    logic [15:0]    epoch;
    logic           busy;

    train_sequencer_if #(.NX(NX), .BITS(BITS), .AW(AW)) bus ();

    train_sequencer #(
        .NX      (NX),
        .BITS    (BITS),
        .NTRAIN  (NTRAIN),
        .NVAL    (NVAL),
        .EPOCHS  (EPOCHS),
        .LR_INIT (LR_INIT),
        .LR_DECAY(LR_DECAY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .END      (END),
        .err_count(err_count),
        .last_err (last_err),
        .epoch    (epoch),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NX-1:0][BITS-1:0] mem_x [0:(1<<AW)-1];
    logic [BITS-1:0]         mem_y [0:(1<<AW)-1];
    bit                      err_plan [0:NPLAN-1];

    // Synchronous pattern memory: one cycle read latency.
    always @(posedge clk) begin
        bus.pat_x <= mem_x[bus.pat_addr];
        bus.pat_y <= mem_y[bus.pat_addr];
    end

    int    n_checks;
    int    n_pass;
    ev_t   ev_q[$];
    ev_t   exp_ev_q[$];
    snap_t snap_q[$];
    snap_t exp_snap_q[$];
    bit    overlap_seen;
    bit    unstable_seen;

    task automatic randomize_mem();
        for (int p = 0; p < (1 << AW); p++) begin
            for (int i = 0; i < NX; i++) mem_x[p][i] = $urandom;
            mem_y[p] = $urandom;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.S_Train = 1'b0;
        bus.S_Error = 1'b0;
        bus.Error   = '0;
        start       = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Reference: walk epochs in pattern order, apply the stop and decay rules.
    task automatic build_model();
        logic [BITS-1:0] lr;
        int              errs;
        ev_t             ev;
        snap_t           sn;
        exp_ev_q.delete();
        exp_snap_q.delete();
        lr = LR_INIT;
        for (int e = 1; e <= EPOCHS; e++) begin
            errs = 0;
            for (int p = 0; p < NPAT; p++) begin
                ev.is_val = (p >= NTRAIN);
                ev.x      = mem_x[p];
                ev.y      = mem_y[p];
                ev.lr     = lr;
                exp_ev_q.push_back(ev);
                if (p >= NTRAIN && err_plan[(e - 1) * NVAL + p - NTRAIN]) errs++;
            end
            if (e % LR_DECAY == 0) lr = (lr / 2 == 0) ? 1 : lr / 2;
            sn.epoch     = 16'(e);
            sn.last_err  = EW'(errs);
            sn.err_count = '0;
            sn.lr        = lr;
            sn.tr        = 1'b0;
            sn.vl        = 1'b0;
            sn.fin       = (errs == 0 || e == EPOCHS);
            sn.busy      = !sn.fin;
            exp_snap_q.push_back(sn);
            if (sn.fin) break;
        end
    endtask

    // Behavioural network: random response delay, random hold, stray opposite-strobes.
    task automatic net_run(input int max_cycles, input int stop_vl, output bit timed_out);
        int          phase;
        int          wait_c;
        int          hold;
        int          vl_ord;
        bit          cur_val;
        bit          cur_err;
        ev_t         ev;
        snap_t       sn;
        logic [15:0] prev_epoch;
        phase = 0; wait_c = 0; hold = 0; vl_ord = 0; cur_val = 0; cur_err = 0;
        ev = '0;
        ev_q.delete();
        snap_q.delete();
        overlap_seen  = 1'b0;
        unstable_seen = 1'b0;
        prev_epoch    = epoch;
        timed_out     = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clk); #1;
            if (bus.TR && bus.VL) overlap_seen = 1'b1;
            if (epoch != prev_epoch) begin
                sn.epoch = epoch; sn.last_err = last_err; sn.err_count = err_count;
                sn.lr = bus.lr; sn.tr = bus.TR; sn.vl = bus.VL; sn.fin = END; sn.busy = busy;
                snap_q.push_back(sn);
                prev_epoch = epoch;
            end
            if (END) begin
                timed_out = 1'b0;
                break;
            end
            if (phase == 0 && (bus.TR || bus.VL)) begin
                ev.is_val = bus.VL; ev.x = bus.x; ev.y = bus.y; ev.lr = bus.lr;
                ev_q.push_back(ev);
                cur_val = bus.VL;
                if (cur_val) begin
                    cur_err = (vl_ord < NPLAN) ? err_plan[vl_ord] : 1'b0;
                    vl_ord++;
                    if (vl_ord == stop_vl) begin
                        timed_out = 1'b0;
                        break;
                    end
                end
                wait_c = $urandom_range(0, 3);
                phase  = 1;
            end
            if (phase == 1) begin
                if ((cur_val ? !bus.VL : !bus.TR) || bus.x !== ev.x || bus.y !== ev.y
                    || bus.lr !== ev.lr) unstable_seen = 1'b1;
                if (wait_c == 0) begin
                    bus.S_Train = !cur_val;
                    bus.S_Error = cur_val;
                    bus.Error   = (cur_val && !cur_err) ? '0 : ($urandom | 32'h1);
                    hold  = $urandom_range(1, 2);
                    phase = 2;
                end else begin
                    wait_c--;
                    if (cur_val) begin
                        bus.S_Train = 1'($urandom_range(0, 1));
                    end else begin
                        bus.S_Error = 1'($urandom_range(0, 1));
                        bus.Error   = $urandom | 32'h1;
                    end
                end
            end else if (phase == 2) begin
                if (bus.TR || bus.VL || bus.x !== ev.x || bus.y !== ev.y) unstable_seen = 1'b1;
                hold--;
                if (hold == 0) begin
                    bus.S_Train = 1'b0;
                    bus.S_Error = 1'b0;
                    bus.Error   = $urandom;
                    phase = 0;
                end
            end
        end
        bus.S_Train = 1'b0;
        bus.S_Error = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        bus.S_Train = 1'b0; bus.S_Error = 1'b0; bus.Error = '0;
        #3 rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.TR !== 1'b0 || bus.VL !== 1'b0 || END !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_ctrl: TR=%b VL=%b END=%b busy=%b want all 0",
                     bus.TR, bus.VL, END, busy);
        end else n_pass++;
        n_checks++;
        if (err_count !== '0 || last_err !== '0 || epoch !== 16'd0 || bus.pat_addr !== '0) begin
            $display("FAIL reset_counts: err=%0d last=%0d epoch=%0d addr=%0d want 0",
                     err_count, last_err, epoch, bus.pat_addr);
        end else n_pass++;
        n_checks++;
        if (bus.lr !== LR_INIT) $display("FAIL reset_lr: got %h want %h", bus.lr, LR_INIT);
        else n_pass++;
        n_checks++;
        if (bus.x !== '0 || bus.y !== '0) $display("FAIL reset_xy: x=%h y=%h want 0", bus.x, bus.y);
        else n_pass++;
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_start_held: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_first_pattern();
        bit tr_drop;
        randomize_mem();
        for (int i = 0; i < NX; i++) mem_x[0][i] = BITS'(i + 1);
        mem_y[0] = 32'd1;
        start_run();
        n_checks++;
        if (bus.TR !== 1'b0 || busy !== 1'b1 || bus.pat_addr !== '0) begin
            $display("FAIL fetch_cycle: TR=%b busy=%b addr=%0d want 0/1/0", bus.TR, busy, bus.pat_addr);
        end else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.TR !== 1'b0) $display("FAIL load_cycle_tr: got %b want 0", bus.TR);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.TR !== 1'b1 || bus.x !== mem_x[0] || bus.y !== 32'd1 || bus.lr !== LR_INIT) begin
            $display("FAIL first_tr: TR=%b x=%h y=%0d want 1 x=%h y=1", bus.TR, bus.x, bus.y, mem_x[0]);
        end else n_pass++;
        tr_drop = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            if (bus.TR !== 1'b1) tr_drop = 1'b1;
        end
        n_checks++;
        if (tr_drop) $display("FAIL tr_hold: TR dropped without S_Train, want held");
        else n_pass++;
        bus.S_Train = 1'b1;
        @(posedge clk); #1;
        bus.S_Train = 1'b0;
        n_checks++;
        if (bus.TR !== 1'b0 || bus.x !== mem_x[0]) begin
            $display("FAIL tr_drop: TR=%b x=%h want 0 x=%h", bus.TR, bus.x, mem_x[0]);
        end else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.pat_addr !== 3'd1 || bus.TR !== 1'b0) begin
            $display("FAIL next_addr: addr=%0d TR=%b want 1/0", bus.pat_addr, bus.TR);
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.TR !== 1'b1 || bus.x !== mem_x[1] || bus.y !== mem_y[1]) begin
            $display("FAIL second_tr: TR=%b x=%h want 1 x=%h", bus.TR, bus.x, mem_x[1]);
        end else n_pass++;
        apply_reset();
    endtask

    task automatic test_validation_counting();
        bit to;
        int ntr;
        int nvl;
        bit cnt_bad;
        randomize_mem();
        for (int i = 0; i < NPLAN; i++) err_plan[i] = 1'b1;
        err_plan[0] = 1'b1;
        err_plan[1] = 1'b0;
        start_run();
        net_run(2000, 0, to);
        n_checks++;
        if (to) $display("FAIL valcount_timeout: END not seen, want END within budget");
        else n_pass++;
        n_checks++;
        if (snap_q[0].epoch !== 16'd1 || snap_q[0].last_err !== 2'd1) begin
            $display("FAIL valcount_epoch1: epoch=%0d last_err=%0d want 1/1",
                     snap_q[0].epoch, snap_q[0].last_err);
        end else n_pass++;
        cnt_bad = (ev_q.size() != EPOCHS * NPAT);
        for (int e = 0; e < EPOCHS; e++) begin
            ntr = 0; nvl = 0;
            for (int p = 0; p < NPAT; p++) begin
                if (e * NPAT + p < ev_q.size()) begin
                    if (ev_q[e * NPAT + p].is_val) nvl++;
                    else ntr++;
                end
            end
            if (ntr != NTRAIN || nvl != NVAL) cnt_bad = 1'b1;
        end
        n_checks++;
        if (cnt_bad) $display("FAIL valcount_trvl: events=%0d per-epoch TR/VL off, want 4 TR 2 VL x3",
                              ev_q.size());
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_early_stop();
        bit to;
        randomize_mem();
        for (int i = 0; i < NPLAN; i++) err_plan[i] = 1'b0;
        start_run();
        net_run(2000, 0, to);
        n_checks++;
        if (to || END !== 1'b1 || epoch !== 16'd1 || busy !== 1'b0) begin
            $display("FAIL early_stop: to=%b END=%b epoch=%0d busy=%b want 0/1/1/0", to, END, epoch, busy);
        end else n_pass++;
        n_checks++;
        if (last_err !== '0 || ev_q.size() != NPAT) begin
            $display("FAIL early_stop_len: last_err=%0d events=%0d want 0/%0d", last_err, ev_q.size(), NPAT);
        end else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (END !== 1'b1) $display("FAIL end_sticky: END=%b want 1", END);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_epoch_limit_decay();
        bit to;
        randomize_mem();
        for (int i = 0; i < NPLAN; i++) err_plan[i] = 1'b1;
        start_run();
        net_run(2000, 0, to);
        n_checks++;
        if (to || END !== 1'b1 || epoch !== 16'd3 || last_err !== 2'd2) begin
            $display("FAIL epoch_limit: to=%b END=%b epoch=%0d last_err=%0d want 0/1/3/2",
                     to, END, epoch, last_err);
        end else n_pass++;
        n_checks++;
        if (bus.lr !== 32'h80 || snap_q[0].lr !== 32'h100 || snap_q[1].lr !== 32'h80) begin
            $display("FAIL lr_decay: final=%h ep1=%h ep2=%h want 80/100/80",
                     bus.lr, snap_q[0].lr, snap_q[1].lr);
        end else n_pass++;
        n_checks++;
        if (ev_q[NPAT].lr !== 32'h100 || ev_q[2 * NPAT].lr !== 32'h80) begin
            $display("FAIL lr_in_epoch: ep2=%h ep3=%h want 100/80", ev_q[NPAT].lr, ev_q[2 * NPAT].lr);
        end else n_pass++;
        apply_reset();
    endtask

    task automatic test_back_to_back(input int runs);
        bit to;
        bit bad;
        for (int r = 0; r < runs; r++) begin
            randomize_mem();
            for (int i = 0; i < NPLAN; i++) err_plan[i] = ($urandom_range(0, 3) != 0);
            build_model();
            start_run();
            n_checks++;
            if (epoch !== 16'd0 || last_err !== '0 || END !== 1'b0 || bus.lr !== LR_INIT) begin
                $display("FAIL restart_init: epoch=%0d last=%0d END=%b lr=%h want 0/0/0/%h",
                         epoch, last_err, END, bus.lr, LR_INIT);
            end else n_pass++;
            net_run(2000, 0, to);
            n_checks++;
            if (to) $display("FAIL run_timeout: run %0d END not seen within budget", r);
            else n_pass++;
            bad = (ev_q.size() != exp_ev_q.size());
            if (bad) $display("FAIL run_events_len: run %0d got %0d want %0d", r, ev_q.size(),
                              exp_ev_q.size());
            for (int i = 0; i < ev_q.size() && i < exp_ev_q.size(); i++) begin
                if (!bad && ev_q[i] !== exp_ev_q[i]) begin
                    bad = 1'b1;
                    $display("FAIL run_event: run %0d idx %0d got %h want %h", r, i, ev_q[i], exp_ev_q[i]);
                end
            end
            n_checks++;
            if (!bad) n_pass++;
            bad = (snap_q.size() != exp_snap_q.size());
            if (bad) $display("FAIL run_epochs_len: run %0d got %0d want %0d", r, snap_q.size(),
                              exp_snap_q.size());
            for (int i = 0; i < snap_q.size() && i < exp_snap_q.size(); i++) begin
                if (!bad && snap_q[i] !== exp_snap_q[i]) begin
                    bad = 1'b1;
                    $display("FAIL run_epoch_end: run %0d epoch %0d got %h want %h",
                             r, i + 1, snap_q[i], exp_snap_q[i]);
                end
            end
            n_checks++;
            if (!bad) n_pass++;
            n_checks++;
            if (overlap_seen || unstable_seen) begin
                $display("FAIL run_handshake: run %0d overlap=%b unstable=%b want 0/0",
                         r, overlap_seen, unstable_seen);
            end else n_pass++;
        end
        apply_reset();
    endtask

    task automatic test_abort();
        bit to;
        randomize_mem();
        for (int i = 0; i < NPLAN; i++) err_plan[i] = 1'b0;
        err_plan[0] = 1'b1;
        start_run();
        net_run(2000, 2, to);
        n_checks++;
        if (to || bus.VL !== 1'b1 || err_count !== 2'd1) begin
            $display("FAIL abort_setup: to=%b VL=%b err_count=%0d want 0/1/1", to, bus.VL, err_count);
        end else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.VL !== 1'b0 || busy !== 1'b0 || err_count !== '0 || epoch !== 16'd0
            || last_err !== '0) begin
            $display("FAIL abort: VL=%b busy=%b err=%0d epoch=%0d last=%0d want all 0",
                     bus.VL, busy, err_count, epoch, last_err);
        end else n_pass++;
        n_checks++;
        if (bus.lr !== LR_INIT || bus.pat_addr !== '0) begin
            $display("FAIL abort_lr_addr: lr=%h addr=%0d want %h/0", bus.lr, bus.pat_addr, LR_INIT);
        end else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || END !== 1'b0) $display("FAIL abort_idle: busy=%b END=%b want 0/0", busy, END);
        else n_pass++;
    endtask

    task automatic test_handshake();
        bit tr_seen;
        bit moved;
        randomize_mem();
        start_run();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.TR !== 1'b1) $display("FAIL hs_tr_up: got %b want 1", bus.TR);
        else n_pass++;
        bus.S_Train = 1'b1;
        bus.S_Error = 1'b1;
        bus.Error   = 32'h5;
        start       = 1'b1;
        tr_seen = 1'b0;
        moved   = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.TR !== 1'b0) tr_seen = 1'b1;
            if (bus.pat_addr !== '0 || err_count !== '0 || epoch !== 16'd0 || busy !== 1'b1) moved = 1'b1;
        end
        bus.S_Train = 1'b0;
        bus.S_Error = 1'b0;
        bus.Error   = '0;
        start       = 1'b0;
        n_checks++;
        if (tr_seen) $display("FAIL hs_tr_held_low: TR rose while S_Train high, want 0");
        else n_pass++;
        n_checks++;
        if (moved) $display("FAIL hs_ignored: addr/err/epoch/busy moved while held, want unchanged");
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.pat_addr !== 3'd1 || bus.TR !== 1'b0) begin
            $display("FAIL hs_release: addr=%0d TR=%b want 1/0", bus.pat_addr, bus.TR);
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.TR !== 1'b1 || bus.x !== mem_x[1]) begin
            $display("FAIL hs_next_tr: TR=%b x=%h want 1 x=%h", bus.TR, bus.x, mem_x[1]);
        end else n_pass++;
        apply_reset();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_first_pattern();
        test_validation_counting();
        test_early_stop();
        test_epoch_limit_decay();
        test_back_to_back(6);
        test_abort();
        test_handshake();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
